// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the instruction encoder, decoder and
// immediate extender: opcode constants, the 3-bit immediate-format code
// (imm_src) and the encoder session FSM state encoding.
// No ports; import with "import riscv_pkg::*;".
package riscv_pkg;

   localparam logic [6:0] OP_ITYPEA = 7'b0010011;  // ALU immediate
   localparam logic [6:0] OP_ITYPEL = 7'b0000011;  // loads
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STYPE  = 7'b0100011;
   localparam logic [6:0] OP_BTYPE  = 7'b1100011;
   localparam logic [6:0] OP_JTYPE  = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;

   typedef enum logic [2:0] {
      IMM_I = 3'b000,
      IMM_S = 3'b001,
      IMM_B = 3'b010,
      IMM_J = 3'b011,
      IMM_U = 3'b100,
      IMM_R = 3'b111
   } imm_src_t;

   typedef logic [1:0] enc_state_t;
   localparam enc_state_t ST_IDLE  = 2'd0;
   localparam enc_state_t ST_RUN   = 2'd1;
   localparam enc_state_t ST_FLUSH = 2'd2;
   localparam enc_state_t ST_DONE  = 2'd3;

   // True when the opcode belongs to the given format code.
   function automatic logic fmt_op_legal(input logic [2:0] fmt, input logic [6:0] op);
      logic ok;
      ok = 1'b0;
      case (fmt)
         IMM_I:   ok = (op == OP_ITYPEA) || (op == OP_ITYPEL) || (op == OP_JALR);
         IMM_S:   ok = (op == OP_STYPE);
         IMM_B:   ok = (op == OP_BTYPE);
         IMM_J:   ok = (op == OP_JTYPE);
         IMM_U:   ok = (op == OP_LUI) || (op == OP_AUIPC);
         IMM_R:   ok = (op == OP_RTYPE);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/imm_packer.sv
// Places a full-width immediate into its RV32I instruction-word bit positions
// and checks that the value is representable in the given format.
// Ports:
//   fmt      in  3   format code (imm_src)
//   imm      in  32  full signed immediate
//   placed   out 32  immediate bits at their final positions, all other bits 0
//   range_ok out 1   immediate is encodable for fmt (always 1 for R and unknown codes)
module imm_packer
   import riscv_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] imm,
   output logic [31:0] placed,
   output logic        range_ok
);

   // A value fits in N signed bits when everything above bit N-1 is a sign copy.
   logic fits12, fits13, fits21;
   assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
   assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
   assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      placed   = '0;
      range_ok = 1'b1;
      case (fmt)
         IMM_I: begin
            placed   = {imm[11:0], 20'b0};
            range_ok = fits12;
         end
         IMM_S: begin
            placed   = {imm[11:5], 13'b0, imm[4:0], 7'b0};
            range_ok = fits12;
         end
         IMM_B: begin
            placed   = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
            range_ok = fits13 & ~imm[0];
         end
         IMM_J: begin
            placed   = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
            range_ok = fits21 & ~imm[0];
         end
         IMM_U: begin
            placed   = {imm[31:12], 12'b0};
            range_ok = ~(|imm[11:0]);
         end
         default: begin
            placed   = '0;
            range_ok = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder/loader. Accepts field-level instruction
// descriptors on a valid/ready stream during a start..in_last session, packs
// each into a 32-bit word and writes it to consecutive instruction-memory words.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               pulse, begins a session (only honoured in IDLE)
//   in_valid/in_ready   descriptor handshake; in_last ends the session
//   in_fmt..in_imm      descriptor fields (format code, opcode, regs, functs, immediate)
//   mem_we/addr/wdata   one-cycle write pulse per committed word
//   words_written       words committed this session
//   busy, done          session in progress / one-cycle end-of-session pulse
//   err_imm/fmt/full    sticky error flags, cleared by start or reset
module instr_encoder
   import riscv_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned MAX_WORDS = 256,
   parameter int unsigned CNT_W     = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [2:0]       in_fmt,
   input  logic [6:0]       in_opcode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [31:0]      in_imm,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [CNT_W-1:0] words_written,
   output logic             busy,
   output logic             done,
   output logic             err_imm,
   output logic             err_fmt,
   output logic             err_full
);

   enc_state_t       state_q, state_d;
   logic [CNT_W-1:0] index_q;
   logic             we_q;
   logic [31:0]      addr_q, wdata_q;
   logic             err_imm_q, err_fmt_q, err_full_q;

   logic        has_room, accept, fmt_ok, range_ok, commit;
   logic [31:0] imm_bits, field_bits, word;

   imm_packer u_imm_packer (
      .fmt      (in_fmt),
      .imm      (in_imm),
      .placed   (imm_bits),
      .range_ok (range_ok)
   );

   assign has_room = index_q < CNT_W'(MAX_WORDS);
   assign in_ready = (state_q == ST_RUN) && has_room;
   assign accept   = in_valid && in_ready;
   assign fmt_ok   = fmt_op_legal(in_fmt, in_opcode);
   // Dropped descriptors are still accepted; only legal, in-range ones are written.
   assign commit   = accept && fmt_ok && range_ok;

   // Register/funct fields; only the ones the format uses are placed.
   always_comb begin
      field_bits      = '0;
      field_bits[6:0] = in_opcode;
      case (in_fmt)
         IMM_I: begin
            field_bits[11:7]  = in_rd;
            field_bits[14:12] = in_funct3;
            field_bits[19:15] = in_rs1;
         end
         IMM_S, IMM_B: begin
            field_bits[14:12] = in_funct3;
            field_bits[19:15] = in_rs1;
            field_bits[24:20] = in_rs2;
         end
         IMM_J, IMM_U: begin
            field_bits[11:7] = in_rd;
         end
         IMM_R: begin
            field_bits[11:7]  = in_rd;
            field_bits[14:12] = in_funct3;
            field_bits[19:15] = in_rs1;
            field_bits[24:20] = in_rs2;
            field_bits[31:25] = in_funct7;
         end
         default: field_bits[6:0] = in_opcode;
      endcase
   end

   assign word = field_bits | imm_bits;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (accept && in_last) state_d = ST_FLUSH;
         ST_FLUSH: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         index_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_imm_q  <= 1'b0;
         err_fmt_q  <= 1'b0;
         err_full_q <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= commit;
         if (commit) begin
            addr_q  <= BASE_ADDR + (32'(index_q) << 2);
            wdata_q <= word;
            index_q <= index_q + CNT_W'(1);
         end
         if (state_q == ST_IDLE && start) begin
            index_q    <= '0;
            err_imm_q  <= 1'b0;
            err_fmt_q  <= 1'b0;
            err_full_q <= 1'b0;
         end else begin
            if (accept && !fmt_ok) err_fmt_q <= 1'b1;
            // Format errors take precedence; the range is only judged for legal pairs.
            if (accept && fmt_ok && !range_ok) err_imm_q <= 1'b1;
            if (state_q == ST_RUN && in_valid && !has_room) err_full_q <= 1'b1;
         end
      end
   end

   assign mem_we        = we_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign words_written = index_q;
   assign busy          = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign done          = (state_q == ST_DONE);
   assign err_imm       = err_imm_q;
   assign err_fmt       = err_fmt_q;
   assign err_full      = err_full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, hand-written
// multi-cycle sequences (drops, reset abort, full buffer) and randomized
// sessions checked against an arithmetic reference encoder.
module tb_instr_encoder;

   logic        clk, reset, start, in_valid, in_last;
   logic [2:0]  in_fmt, in_funct3;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic        in_ready, mem_we, busy, done, err_imm, err_fmt, err_full;
   logic [31:0] mem_addr, mem_wdata;
   logic [8:0]  words_written;

   logic        s_reset, s_start, s_valid, s_last;
   logic        s_ready, s_we, s_busy, s_done, s_err_imm, s_err_fmt, s_err_full;
   logic [31:0] s_addr, s_wdata;
   logic [1:0]  s_words;

   int checks = 0;
   int failures = 0;

   instr_encoder #(.BASE_ADDR(32'h0), .MAX_WORDS(256), .CNT_W(9)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .words_written(words_written), .busy(busy), .done(done), .err_imm(err_imm),
      .err_fmt(err_fmt), .err_full(err_full)
   );

   instr_encoder #(.BASE_ADDR(32'h100), .MAX_WORDS(2), .CNT_W(2)) dut_small (
      .clk(clk), .reset(s_reset), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
      .in_last(s_last), .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_imm(in_imm), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
      .words_written(s_words), .busy(s_busy), .done(s_done), .err_imm(s_err_imm),
      .err_fmt(s_err_fmt), .err_full(s_err_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  fmt;
      logic [6:0]  op;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } desc_t;

   typedef struct {
      desc_t       d;
      logic        wr;
      logic [31:0] word;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic desc_t mk(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm);
      desc_t d;
      d.fmt = f; d.op = op; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2;
      d.f3 = f3; d.f7 = f7; d.imm = imm;
      return d;
   endfunction

   task automatic drive(input desc_t d);
      in_fmt = d.fmt; in_opcode = d.op; in_rd = d.rd; in_rs1 = d.rs1; in_rs2 = d.rs2;
      in_funct3 = d.f3; in_funct7 = d.f7; in_imm = d.imm;
   endtask

   // Reference encoder from the ISA rules. kind: 0 written, 1 format error, 2 immediate error.
   function automatic void model(input desc_t d, output int kind, output logic [31:0] w);
      logic [31:0] u, op, rd, rs1, rs2, f3, f7;
      int   v;
      logic legal, in_range;
      u = d.imm; op = 32'(d.op); rd = 32'(d.rd); rs1 = 32'(d.rs1); rs2 = 32'(d.rs2);
      f3 = 32'(d.f3); f7 = 32'(d.f7);
      v = $signed(d.imm);
      legal = 1'b0; in_range = 1'b1; w = 32'h0;
      case (d.fmt)
         3'd0: begin
            legal = (d.op == 7'h13) || (d.op == 7'h03) || (d.op == 7'h67);
            in_range = (v >= -2048) && (v <= 2047);
            w = ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
         end
         3'd1: begin
            legal = (d.op == 7'h23);
            in_range = (v >= -2048) && (v <= 2047);
            w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                | ((u & 32'h1F) << 7) | op;
         end
         3'd2: begin
            legal = (d.op == 7'h63);
            in_range = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20)
                | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hF) << 8)
                | (((u >> 11) & 1) << 7) | op;
         end
         3'd3: begin
            legal = (d.op == 7'h6F);
            in_range = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | op;
         end
         3'd4: begin
            legal = (d.op == 7'h37) || (d.op == 7'h17);
            in_range = (u % 4096) == 0;
            w = (u & 32'hFFFFF000) | (rd << 7) | op;
         end
         3'd7: begin
            legal = (d.op == 7'h33);
            w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
         end
         default: legal = 1'b0;
      endcase
      kind = !legal ? 1 : (!in_range ? 2 : 0);
   endfunction

   function automatic desc_t rand_desc();
      desc_t d;
      int    r;
      d = mk(3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             3'($urandom), 7'($urandom), $urandom);
      r = $urandom_range(0, 15);
      if (r < 14) begin
         case (r % 6)
            0: d.fmt = 3'd0;
            1: d.fmt = 3'd1;
            2: d.fmt = 3'd2;
            3: d.fmt = 3'd3;
            4: d.fmt = 3'd4;
            default: d.fmt = 3'd7;
         endcase
      end else begin
         d.fmt = (r == 14) ? 3'd5 : 3'd6;
      end
      if ($urandom_range(0, 7) != 0) begin
         case (d.fmt)
            3'd0: case ($urandom_range(0, 2))
                     0: d.op = 7'h13;
                     1: d.op = 7'h03;
                     default: d.op = 7'h67;
                  endcase
            3'd1: d.op = 7'h23;
            3'd2: d.op = 7'h63;
            3'd3: d.op = 7'h6F;
            3'd4: d.op = $urandom_range(0, 1) ? 7'h37 : 7'h17;
            default: d.op = 7'h33;
         endcase
      end
      case ($urandom_range(0, 3))
         0: d.imm = $urandom;
         1: d.imm = 32'($urandom_range(0, 8192)) - 32'd4096;
         2: d.imm = 32'($urandom_range(0, 2097152)) - 32'h0010_0000;
         default: d.imm = $urandom & 32'hFFFFF000;
      endcase
      if ($urandom_range(0, 1) != 0) d.imm[0] = 1'b0;
      return d;
   endfunction

   vec_t vt[20];

   initial begin
      int    nw, kind, e_idx, len, gaps;
      logic  e_ei, e_ef;
      logic [31:0] w;
      desc_t d;

      vt[0]  = '{mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd31, 3'd0, 7'h7F, 32'd5), 1'b1, 32'h00500093};
      vt[1]  = '{mk(3'd1, 7'h23, 5'd9, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), 1'b1, 32'h0020A423};
      vt[2]  = '{mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC), 1'b1, 32'hFE000EE3};
      vt[3]  = '{mk(3'd4, 7'h37, 5'd5, 5'd3, 5'd4, 3'd7, 7'd0, 32'h12345000), 1'b1, 32'h123452B7};
      vt[4]  = '{mk(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0), 1'b1, 32'h002081B3};
      vt[5]  = '{mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), 1'b0, 32'h0};
      vt[6]  = '{mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3), 1'b0, 32'h0};
      vt[7]  = '{mk(3'd1, 7'h33, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0), 1'b0, 32'h0};
      vt[8]  = '{mk(3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800), 1'b1, 32'h80000093};
      vt[9]  = '{mk(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000FFFFE), 1'b1, 32'h7FFFF0EF};
      vt[10] = '{mk(3'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000), 1'b0, 32'h0};
      vt[11] = '{mk(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1), 1'b0, 32'h0};
      vt[12] = '{mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001), 1'b0, 32'h0};
      vt[13] = '{mk(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFF), 1'b1, 32'h002081B3};
      vt[14] = '{mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000FFE), 1'b1, 32'h7E000FE3};
      vt[15] = '{mk(3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000), 1'b1, 32'h80000063};
      vt[16] = '{mk(3'd0, 7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0), 1'b1, 32'h00008067};
      vt[17] = '{mk(3'd4, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000), 1'b1, 32'h00001117};
      vt[18] = '{mk(3'd0, 7'h03, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFF), 1'b1, 32'hFFF12203};
      vt[19] = '{mk(3'd1, 7'h23, 5'd0, 5'd0, 5'd0, 3'd2, 7'd0, 32'h000007FF), 1'b1, 32'h7E002FA3};

      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      s_reset = 1'b1; s_start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
      drive(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
      step(); step();
      chk("reset_we", mem_we, 0); chk("reset_addr", mem_addr, 0);
      chk("reset_wdata", mem_wdata, 0); chk("reset_words", words_written, 0);
      chk("reset_busy", busy, 0); chk("reset_done", done, 0); chk("reset_ready", in_ready, 0);
      chk("reset_errs", {err_imm, err_fmt, err_full}, 0);
      reset = 1'b0; s_reset = 1'b0;
      step();

      // Session of dropped descriptors only.
      start = 1'b1; step(); start = 1'b0;
      chk("drop_busy", busy, 1);
      for (int i = 5; i <= 7; i++) begin
         drive(vt[i].d); in_valid = 1'b1; in_last = (i == 7);
         step();
         chk("drop_we", mem_we, 0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      step();
      chk("drop_done", done, 1); chk("drop_words", words_written, 0);
      chk("drop_err_imm", err_imm, 1); chk("drop_err_fmt", err_fmt, 1);
      chk("drop_err_full", err_full, 0); chk("drop_we_end", mem_we, 0);
      step();

      // Table session, back-to-back descriptors.
      start = 1'b1; step(); start = 1'b0;
      chk("tbl_err_clear", {err_imm, err_fmt, err_full}, 0);
      chk("tbl_words0", words_written, 0);
      nw = 0;
      for (int i = 0; i < 20; i++) begin
         drive(vt[i].d); in_valid = 1'b1; in_last = (i == 19);
         #1 chk("tbl_ready", in_ready, 1);
         step();
         chk($sformatf("tbl%0d_we", i), mem_we, vt[i].wr);
         if (vt[i].wr) begin
            chk($sformatf("tbl%0d_addr", i), mem_addr, 32'(4 * nw));
            chk($sformatf("tbl%0d_wdata", i), mem_wdata, vt[i].word);
            nw++;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("tbl_flush_busy", busy, 1); chk("tbl_flush_done", done, 0);
      step();
      chk("tbl_done", done, 1); chk("tbl_done_busy", busy, 0); chk("tbl_done_we", mem_we, 0);
      chk("tbl_words", words_written, 14);
      chk("tbl_errs", {err_imm, err_fmt, err_full}, 3'b110);
      step();
      chk("tbl_done_pulse", done, 0);

      // Randomized sessions against the reference model.
      for (int s = 0; s < 40; s++) begin
         start = 1'b1; step(); start = 1'b0;
         e_idx = 0; e_ei = 1'b0; e_ef = 1'b0;
         len = $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < gaps; g++) begin
               d = rand_desc(); drive(d); in_valid = 1'b0; in_last = 1'b1;
               step();
               chk("rnd_gap_we", mem_we, 0);
            end
            d = rand_desc(); drive(d); in_valid = 1'b1; in_last = (k == len - 1);
            model(d, kind, w);
            step();
            if (kind == 0) begin
               chk("rnd_we", mem_we, 1);
               chk("rnd_addr", mem_addr, 32'(4 * e_idx));
               chk("rnd_wdata", mem_wdata, w);
               e_idx++;
            end else begin
               chk("rnd_drop_we", mem_we, 0);
               if (kind == 1) e_ef = 1'b1; else e_ei = 1'b1;
            end
         end
         in_valid = 1'b0; in_last = 1'b0;
         step();
         chk("rnd_done", done, 1);
         chk("rnd_words", words_written, 32'(e_idx));
         chk("rnd_errs", {err_imm, err_fmt}, {e_ei, e_ef});
         step();
      end

      // Reset in the middle of a session.
      start = 1'b1; step(); start = 1'b0;
      drive(vt[5].d); in_valid = 1'b1; step();
      chk("rst_pre_err", err_imm, 1);
      drive(vt[0].d); step(); step();
      chk("rst_pre_we", mem_we, 1); chk("rst_pre_addr", mem_addr, 32'h4);
      drive(vt[4].d); reset = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b0;
      chk("rst_we", mem_we, 0); chk("rst_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
      chk("rst_words", words_written, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      chk("rst_errs", {err_imm, err_fmt, err_full}, 0);
      #1 chk("rst_ready", in_ready, 0);
      step();
      start = 1'b1; step(); start = 1'b0;
      drive(vt[3].d); in_valid = 1'b1; in_last = 1'b1; step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("rst_again_we", mem_we, 1); chk("rst_again_addr", mem_addr, 0);
      chk("rst_again_wdata", mem_wdata, 32'h123452B7);
      step(); step();

      // Full buffer on the two-word instance.
      s_start = 1'b1; step(); s_start = 1'b0;
      drive(vt[0].d); s_valid = 1'b1;
      #1 chk("full_ready0", s_ready, 1);
      step();
      chk("full_we0", s_we, 1); chk("full_addr0", s_addr, 32'h100);
      chk("full_wdata0", s_wdata, 32'h00500093);
      drive(vt[4].d);
      step();
      chk("full_we1", s_we, 1); chk("full_addr1", s_addr, 32'h104);
      chk("full_wdata1", s_wdata, 32'h002081B3);
      drive(vt[3].d); s_last = 1'b1;
      #1 chk("full_ready2", s_ready, 0);
      step();
      chk("full_we2", s_we, 0); chk("full_err", s_err_full, 1);
      step();
      chk("full_busy", s_busy, 1); chk("full_done", s_done, 0); chk("full_words", s_words, 2);
      s_valid = 1'b0; s_last = 1'b0; s_start = 1'b1;
      step(); s_start = 1'b0;
      chk("full_start_ignored", s_busy, 1); chk("full_err_kept", s_err_full, 1);
      chk("full_words_kept", s_words, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
